// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type plus the store drain buffer entry and FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;
    word_t       data;
  } sdb_entry_t;

  typedef enum logic {SDB_IDLE, SDB_WRITE} sdb_state_t;

endpackage

// File: rtl/sdb_match.sv
// Youngest-match priority search over the pending-store ring, used for store-to-load forwarding.
module sdb_match
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sdb_entry_t       entries_i [DEPTH],
  input  logic [PTR_W-1:0] head_i,
  input  logic [PTR_W:0]   count_i,
  input  logic [29:0]      waddr_i,
  output logic             hit_o,
  output logic [PTR_W-1:0] idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    // Walk oldest to youngest so the last match (closest to tail) wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count_i)
          && entries_i[head_i + PTR_W'(i)].valid
          && (entries_i[head_i + PTR_W'(i)].waddr == waddr_i)) begin
        hit_o = 1'b1;
        idx_o = head_i + PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/store_drain_buffer.sv
// In-order store drain buffer between MEM and the dcache with store-to-load forwarding.
// Optional in-place coalescing into the youngest entry when STORE_COALESCE_EN is defined.
module store_drain_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  word_t       st_data,
  output logic        st_ready,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output word_t       ld_data,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output word_t       dmemstore,
  input  logic        dwait,
  output logic        empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  sdb_state_t       state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  sdb_entry_t       entries_q [DEPTH];

  logic             pop, push, coalesce;
  logic             match_hit;
  logic [PTR_W-1:0] match_idx;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};
  assign pop = (state_q == SDB_WRITE) && !dwait;

`ifdef STORE_COALESCE_EN
  logic [PTR_W-1:0] young_idx;
  logic             coal_match;

  assign young_idx  = tail_q - 1'b1;
  // The head under an active write is frozen; only younger entries may be rewritten.
  assign coal_match = (count_q != '0)
                      && entries_q[young_idx].valid
                      && (entries_q[young_idx].waddr == st_addr[31:2])
                      && !((state_q == SDB_WRITE) && (young_idx == head_q));
  assign coalesce   = st_req && coal_match;
  assign st_ready   = (count_q < FULL_CNT) || coal_match;
`else
  assign coalesce   = 1'b0;
  assign st_ready   = (count_q < FULL_CNT);
`endif

  assign push = st_req && st_ready && !coalesce;

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    state_d = state_q;
    case (state_q)
      SDB_IDLE:  if (count_q != '0) state_d = SDB_WRITE;
      SDB_WRITE: if (pop && (count_d == '0)) state_d = SDB_IDLE;
      default:   state_d = SDB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SDB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)  entries_q[head_q].valid <= 1'b0;
      if (push) entries_q[tail_q] <= {1'b1, st_addr[31:2], st_data};
`ifdef STORE_COALESCE_EN
      if (coalesce) entries_q[young_idx].data <= st_data;
`endif
    end
  end

  sdb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .waddr_i   (ld_addr[31:2]),
    .hit_o     (match_hit),
    .idx_o     (match_idx)
  );

  assign ld_hit    = ld_req && match_hit;
  assign ld_data   = ld_hit ? entries_q[match_idx].data : '0;
  assign dmemWEN   = (state_q == SDB_WRITE);
  assign dmemaddr  = dmemWEN ? {entries_q[head_q].waddr, 2'b00} : '0;
  assign dmemstore = dmemWEN ? entries_q[head_q].data : '0;
  assign empty     = (count_q == '0);

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: drain-order scoreboard, forwarding and reset checks.
module tb_store_drain_buffer;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST, st_req, ld_req, dwait;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        st_ready, ld_hit, dmemWEN, empty;
  logic [31:0] ld_data, dmemaddr, dmemstore;

  int  n_cmp = 0;
  int  n_err = 0;
  int  mcount = 0;
  wr_t sb[$];

  store_drain_buffer dut (
    .CLK(CLK), .RST(RST),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dwait(dwait), .empty(empty)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    @(posedge CLK); #1;
    RST = 1'b1; st_req = 1'b1; st_addr = 32'h10; st_data = 32'h1;
    ld_req = 1'b1; ld_addr = 32'h0; dwait = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL rst_st_ready act=%0b exp=1", st_ready); end
    n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_err++; $display("FAIL rst_ld act=%0b/%h exp=0/0", ld_hit, ld_data); end
    n_cmp++; if (dmemWEN !== 1'b0 || dmemaddr !== 32'h0 || dmemstore !== 32'h0) begin
      n_err++; $display("FAIL rst_dmem act=%0b/%h/%h exp=0/0/0", dmemWEN, dmemaddr, dmemstore); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty act=%0b exp=1", empty); end
    @(posedge CLK); #1;
    RST = 1'b0; st_req = 1'b0; ld_req = 1'b0;
    @(negedge CLK);
    sb.delete(); mcount = 0;
  endtask

  task automatic test_single_store;
    logic er, ew, ee;
    wr_t  e;
    for (int c = 0; c < 7; c++) begin
      @(posedge CLK); #1;
      st_req = (c == 0); st_addr = 32'h100; st_data = 32'hDEADBEEF;
      dwait = (c <= 4);
      @(negedge CLK);
      er = (mcount < 4);
      ew = (c >= 2 && c <= 5);
      ee = (c == 0 || c == 6);
      n_cmp++; if (st_ready !== er) begin n_err++; $display("FAIL single_st_ready c=%0d act=%0b exp=%0b", c, st_ready, er); end
      n_cmp++; if (dmemWEN !== ew) begin n_err++; $display("FAIL single_wen c=%0d act=%0b exp=%0b", c, dmemWEN, ew); end
      n_cmp++; if (empty !== ee) begin n_err++; $display("FAIL single_empty c=%0d act=%0b exp=%0b", c, empty, ee); end
      if (dmemWEN && !dwait) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL single_drain act=%h exp=none", dmemaddr); end
        else begin
          e = sb.pop_front(); mcount--;
          if (dmemaddr !== e.a || dmemstore !== e.d) begin
            n_err++; $display("FAIL single_drain act=%h/%h exp=%h/%h", dmemaddr, dmemstore, e.a, e.d); end
        end
      end
      if (st_req && er) begin sb.push_back({st_addr & 32'hFFFF_FFFC, st_data}); mcount++; end
    end
  endtask

  task automatic test_fill_drain;
    logic er;
    wr_t  e;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      dwait = (c < 5);
      st_req = (c < 5); st_addr = 32'(c * 4); st_data = 32'hA000_0000 + 32'(c);
      @(negedge CLK);
      er = (mcount < 4);
      n_cmp++; if (st_ready !== er) begin n_err++; $display("FAIL fill_st_ready c=%0d act=%0b exp=%0b", c, st_ready, er); end
      if (c >= 5 && c <= 8) begin
        n_cmp++; if (dmemWEN !== 1'b1) begin n_err++; $display("FAIL fill_b2b c=%0d act=%0b exp=1", c, dmemWEN); end
      end
      if (c == 9) begin
        n_cmp++; if (empty !== 1'b1 || dmemWEN !== 1'b0) begin
          n_err++; $display("FAIL fill_done act=%0b/%0b exp=1/0", empty, dmemWEN); end
      end
      if (dmemWEN && !dwait) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL fill_drain act=%h exp=none", dmemaddr); end
        else begin
          e = sb.pop_front(); mcount--;
          if (dmemaddr !== e.a || dmemstore !== e.d) begin
            n_err++; $display("FAIL fill_drain act=%h/%h exp=%h/%h", dmemaddr, dmemstore, e.a, e.d); end
        end
      end
      if (st_req && er) begin sb.push_back({st_addr & 32'hFFFF_FFFC, st_data}); mcount++; end
    end
    st_req = 1'b0;
  endtask

  task automatic test_forward;
    logic        er, coal, eh;
    logic [31:0] ed;
    wr_t         e;
    for (int c = 0; c < 25; c++) begin
      @(posedge CLK); #1;
      dwait  = (c <= 8);
      st_req = (c <= 2) || (c == 6);
      st_addr = (c == 0) ? 32'h0 : (c == 6) ? 32'h50 : 32'h40;
      st_data = (c == 0) ? 32'hAA : (c == 1) ? 32'h1 : (c == 2) ? 32'h2 : 32'h55;
      ld_req = (c >= 3 && c <= 8 && c != 7);
      case (c)
        3: ld_addr = 32'h42;
        4: ld_addr = 32'h44;
        5: ld_addr = 32'h0;
        6: ld_addr = 32'h50;
        7: ld_addr = 32'h40;
        default: ld_addr = 32'h52;
      endcase
      @(negedge CLK);
      coal = 1'b0;
`ifdef STORE_COALESCE_EN
      if (st_req && sb.size() >= 2 && sb[sb.size()-1].a == (st_addr & 32'hFFFF_FFFC)) coal = 1'b1;
`endif
      er = (mcount < 4) || coal;
      n_cmp++; if (st_ready !== er) begin n_err++; $display("FAIL fwd_st_ready c=%0d act=%0b exp=%0b", c, st_ready, er); end
      if (c >= 3 && c <= 8) begin
        case (c)
          3: begin eh = 1'b1; ed = 32'h2;  end
          5: begin eh = 1'b1; ed = 32'hAA; end
          8: begin eh = 1'b1; ed = 32'h55; end
          default: begin eh = 1'b0; ed = 32'h0; end
        endcase
        n_cmp++; if (ld_hit !== eh || ld_data !== ed) begin
          n_err++; $display("FAIL fwd_ld c=%0d act=%0b/%h exp=%0b/%h", c, ld_hit, ld_data, eh, ed); end
      end
      if (dmemWEN && !dwait) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL fwd_drain act=%h exp=none", dmemaddr); end
        else begin
          e = sb.pop_front(); mcount--;
          if (dmemaddr !== e.a || dmemstore !== e.d) begin
            n_err++; $display("FAIL fwd_drain act=%h/%h exp=%h/%h", dmemaddr, dmemstore, e.a, e.d); end
        end
      end
      if (st_req && er) begin
        if (coal) sb[sb.size()-1].d = st_data;
        else begin sb.push_back({st_addr & 32'hFFFF_FFFC, st_data}); mcount++; end
      end
    end
    st_req = 1'b0; ld_req = 1'b0;
    n_cmp++; if (sb.size() != 0 || empty !== 1'b1) begin
      n_err++; $display("FAIL fwd_flush act=%0d/%0b exp=0/1", sb.size(), empty); end
  endtask

  task automatic test_wrap;
    logic er;
    wr_t  e;
    int   sent = 0;
    for (int c = 0; c < 80 && !(sent == 10 && sb.size() == 0); c++) begin
      @(posedge CLK); #1;
      dwait = (c % 2 == 1);
      st_req = (sent < 10); st_addr = 32'h200 + 32'(sent * 4); st_data = 32'h5A5A_0000 | 32'(sent);
      @(negedge CLK);
      er = (mcount < 4);
      n_cmp++; if (st_ready !== er) begin n_err++; $display("FAIL wrap_st_ready c=%0d act=%0b exp=%0b", c, st_ready, er); end
      if (dmemWEN && !dwait) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL wrap_drain act=%h exp=none", dmemaddr); end
        else begin
          e = sb.pop_front(); mcount--;
          if (dmemaddr !== e.a || dmemstore !== e.d) begin
            n_err++; $display("FAIL wrap_drain act=%h/%h exp=%h/%h", dmemaddr, dmemstore, e.a, e.d); end
        end
      end
      if (st_req && er) begin sb.push_back({st_addr & 32'hFFFF_FFFC, st_data}); mcount++; sent++; end
    end
    st_req = 1'b0;
    @(negedge CLK);
    n_cmp++; if (sent != 10 || sb.size() != 0 || empty !== 1'b1) begin
      n_err++; $display("FAIL wrap_done act=%0d/%0d/%0b exp=10/0/1", sent, sb.size(), empty); end
  endtask

  task automatic test_full_simul;
    logic er;
    wr_t  e;
    for (int c = 0; c < 14; c++) begin
      @(posedge CLK); #1;
      dwait  = (c < 6) || (c == 7);
      st_req = (c < 4) || (c == 6) || (c == 7);
      st_addr = (c < 4) ? 32'h300 + 32'(c * 4) : 32'h310;
      st_data = 32'hC0DE_0000 + 32'(c);
      if (c == 7) st_data = 32'hC0DE_0006;
      @(negedge CLK);
      er = (mcount < 4);
      n_cmp++; if (st_ready !== er) begin n_err++; $display("FAIL full_st_ready c=%0d act=%0b exp=%0b", c, st_ready, er); end
      if (dmemWEN && !dwait) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL full_drain act=%h exp=none", dmemaddr); end
        else begin
          e = sb.pop_front(); mcount--;
          if (dmemaddr !== e.a || dmemstore !== e.d) begin
            n_err++; $display("FAIL full_drain act=%h/%h exp=%h/%h", dmemaddr, dmemstore, e.a, e.d); end
        end
      end
      if (st_req && er) begin sb.push_back({st_addr & 32'hFFFF_FFFC, st_data}); mcount++; end
    end
    st_req = 1'b0;
    n_cmp++; if (sb.size() != 0 || empty !== 1'b1) begin
      n_err++; $display("FAIL full_done act=%0d/%0b exp=0/1", sb.size(), empty); end
  endtask

`ifdef STORE_COALESCE_EN
  task automatic test_coalesce;
    logic er, coal;
    wr_t  e;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      dwait  = (c <= 9);
      st_req = (c == 0) || (c >= 3 && c <= 8);
      case (c)
        0: begin st_addr = 32'h0;  st_data = 32'h77; end
        3: begin st_addr = 32'h80; st_data = 32'h5;  end
        4: begin st_addr = 32'h80; st_data = 32'h9;  end
        5: begin st_addr = 32'h84; st_data = 32'hB;  end
        6: begin st_addr = 32'h88; st_data = 32'hC;  end
        7: begin st_addr = 32'h88; st_data = 32'hD;  end
        default: begin st_addr = 32'h8C; st_data = 32'hE; end
      endcase
      ld_req = (c == 9); ld_addr = 32'h80;
      @(negedge CLK);
      coal = 1'b0;
      if (st_req && sb.size() >= 2 && sb[sb.size()-1].a == (st_addr & 32'hFFFF_FFFC)) coal = 1'b1;
      er = (mcount < 4) || coal;
      n_cmp++; if (st_ready !== er) begin n_err++; $display("FAIL coal_st_ready c=%0d act=%0b exp=%0b", c, st_ready, er); end
      if (c == 9) begin
        n_cmp++; if (ld_hit !== 1'b1 || ld_data !== 32'h9) begin
          n_err++; $display("FAIL coal_ld act=%0b/%h exp=1/9", ld_hit, ld_data); end
      end
      if (dmemWEN && !dwait) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL coal_drain act=%h exp=none", dmemaddr); end
        else begin
          e = sb.pop_front(); mcount--;
          if (dmemaddr !== e.a || dmemstore !== e.d) begin
            n_err++; $display("FAIL coal_drain act=%h/%h exp=%h/%h", dmemaddr, dmemstore, e.a, e.d); end
        end
      end
      if (st_req && er) begin
        if (coal) sb[sb.size()-1].d = st_data;
        else begin sb.push_back({st_addr & 32'hFFFF_FFFC, st_data}); mcount++; end
      end
    end
    st_req = 1'b0; ld_req = 1'b0;
    n_cmp++; if (sb.size() != 0 || empty !== 1'b1) begin
      n_err++; $display("FAIL coal_done act=%0d/%0b exp=0/1", sb.size(), empty); end
  endtask
`endif

  task automatic test_reset_midwrite;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      dwait  = (c <= 4);
      st_req = (c <= 1); st_addr = 32'h400 + 32'(c * 4); st_data = 32'(c + 1);
      RST    = (c == 4);
      ld_req = (c == 5); ld_addr = 32'h400;
      @(negedge CLK);
      if (c == 3) begin
        n_cmp++; if (dmemWEN !== 1'b1 || dmemaddr !== 32'h400) begin
          n_err++; $display("FAIL midrst_wen act=%0b/%h exp=1/400", dmemWEN, dmemaddr); end
      end
      if (c == 5) begin
        n_cmp++; if (dmemWEN !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin
          n_err++; $display("FAIL midrst_state act=%0b/%0b/%0b exp=0/1/1", dmemWEN, empty, st_ready); end
        n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
          n_err++; $display("FAIL midrst_ld act=%0b/%h exp=0/0", ld_hit, ld_data); end
      end
    end
    ld_req = 1'b0;
    sb.delete(); mcount = 0;
  endtask

  initial begin
    RST = 1'b0; st_req = 1'b0; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_addr = '0; dwait = 1'b0;
    test_reset();
    test_single_store();
    test_fill_drain();
    test_forward();
    test_wrap();
    test_full_simul();
`ifdef STORE_COALESCE_EN
    test_coalesce();
`endif
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Small circular buffer between the MEM stage and the dcache port.
- Retired stores are enqueued here and drained to the dcache one at a time, in order, over the dmemWEN/dwait handshake.
- Loads search the buffer; a matching pending store forwards its data (store-to-load forwarding), so MEM does not stall on store latency.
- Sits beside the register-level store forwarding unit; this block handles the memory-side direction (store data flowing into loads).

Parameters:
- DEPTH, 4, number of pending-store entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), width of the head/tail pointers.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- st_req  in  1  enqueue a store this cycle.
- st_addr  in  32  store byte address; bits [1:0] ignored.
- st_data  in  32  store word.
- st_ready  out  1  buffer can accept a store (count < DEPTH).
- ld_req  in  1  a load is searching this cycle.
- ld_addr  in  32  load byte address; bits [1:0] ignored.
- ld_hit  out  1  combinational: a valid entry matches ld_addr.
- ld_data  out  32  data of the youngest matching entry; 0 when no hit.
- dmemWEN  out  1  write request to the dcache.
- dmemaddr  out  32  head entry address, word-aligned.
- dmemstore  out  32  head entry data.
- dwait  in  1  dcache busy; a write completes on a cycle where dmemWEN=1 and dwait=0.
- empty  out  1  count == 0; used by the halt logic for the flush-before-halt check.

Behaviour:
- Reset: clears head, tail, count and all valid bits; FSM goes to IDLE. Reset outputs: st_ready=1, ld_hit=0, ld_data=0, dmemWEN=0, dmemaddr=0, dmemstore=0, empty=1.
- Reset asserted mid-write discards all entries. dmemWEN drops the next cycle.
- Storage: entry = {valid, word address [31:2], data}. head = oldest entry, tail = next free slot. Pointers wrap modulo DEPTH.
- Enqueue: on st_req && st_ready, write the entry at tail; tail++ and count++.
  - st_req while full is ignored. The upstream stage must stall on !st_ready.
- FSM states: IDLE and WRITE.
  - IDLE -> WRITE when count != 0.
  - WRITE drives dmemWEN=1, dmemaddr={head.addr,2'b00}, dmemstore=head.data.
  - In WRITE, when dwait=0: pop the head (valid=0, head++, count--). Go to IDLE if the post-update count is 0, else stay in WRITE. Back-to-back drains therefore need no idle bubble.
  - dmemWEN=0 and dmemaddr/dmemstore=0 in IDLE.
- Simultaneous push and pop: count is unchanged; both pointers advance.
  - When full, a pop does not make st_ready=1 in the same cycle. st_ready is registered-state based (count < DEPTH), with no bypass.
- Load search: combinational over valid entries, including the head currently being written. Youngest (closest to tail) match wins.
  - A store enqueued in the same cycle is not visible to the load; the pipeline forwarding paths cover that case.
  - ld_hit=0 when ld_req=0.
- Ordering: drains are strictly FIFO. The buffer never reorders or merges writes unless the optional feature below is enabled.
- Latency: an enqueued store can appear on dmemWEN no earlier than 2 cycles after enqueue (enqueue edge, then IDLE->WRITE edge).

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined: when st_req matches the word address of the youngest valid entry, and that entry is not the head while in WRITE, overwrite its data in place. tail and count do not change.
  - The coalesced store is accepted even when full; st_ready = (count < DEPTH) || coalesce_match.
- Undefined: every accepted store allocates a new entry; no address compare on the enqueue path.

Decomposition:
- cpu_types_pkg gains:
  - sdb_entry_t, packed struct {logic valid; logic [29:0] waddr; word_t data;}.
  - sdb_state_t enum {SDB_IDLE, SDB_WRITE}.
- Interface file store_drain_buffer_if.vh, with modports sdb (block) and tb (bench).
- One natural sub-module: sdb_match, a combinational youngest-match priority search. Inputs: entry array, head, count, ld_addr. Outputs: hit and index.

Test Plan:
- Reset, then a single store (0x100, 0xDEADBEEF) with dwait held 1 for 3 cycles -> dmemWEN=1 from cycle 2; the entry pops on the first dwait=0 cycle; empty=1 the cycle after.
- Fill 4 stores (0x0, 0x4, 0x8, 0xC) with dwait=1 -> st_ready=0. A 5th st_req is ignored. Release dwait -> drain order is 0x0, 0x4, 0x8, 0xC, back to back.
- Stores 0x40=1 then 0x40=2 pending, then ld 0x42 -> ld_hit=1, ld_data=2. ld 0x44 -> ld_hit=0, ld_data=0.
- Wrap-around: 10 stores with an alternating dwait pattern -> dmemaddr sequence matches enqueue order; pointers wrap without loss.
- Full buffer, simultaneous pop and st_req -> the store is rejected that cycle (st_ready=0) and accepted the next cycle. Count is never above 4.
- With STORE_COALESCE_EN: stores 0x80=5 then 0x80=9 while the head is busy on 0x0 -> count rises by 1 only; 0x80 drains with 9.
